// File: rtl/wb_port_arbiter.sv
// Two-source writeback arbiter for a single register file write port.
// The pipeline (P) wins by default; the multi-cycle source (M) is forced through after STARVE_LIMIT denials.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_waddr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              m_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              grant_src,
  output logic              m_starved
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic       force_m;
  logic       grant_p;
  logic       grant_m;

  always_comb begin
    force_m = m_valid && (cnt_reg == LIMIT);
    grant_p = 1'b0;
    grant_m = 1'b0;
    // Readys are held low for the whole reset pulse, not just until the next edge.
    if (!rst) begin
      if (force_m)      grant_m = 1'b1;
      else if (p_valid) grant_p = 1'b1;
      else if (m_valid) grant_m = 1'b1;
    end
    cnt_next = '0;
    if (m_valid && !grant_m)
      cnt_next = (cnt_reg == LIMIT) ? LIMIT : cnt_reg + 4'd1;
  end

  assign p_ready   = grant_p;
  assign m_ready   = grant_m;
  assign m_starved = (cnt_reg == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      grant_src <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      we      <= 1'b0;
      // A write to register 0 is still accepted, but never enables the port.
      if (grant_p) begin
        we        <= (p_waddr != '0);
        waddr     <= p_waddr;
        wdata     <= p_wdata;
        grant_src <= 1'b0;
      end else if (grant_m) begin
        we        <= (m_waddr != '0);
        waddr     <= m_waddr;
        wdata     <= m_wdata;
        grant_src <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes expected register writes, a monitor pops and checks them.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        p_valid;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        p_ready;
  logic        m_valid;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        grant_src;
  logic        m_starved;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_waddr(p_waddr), .p_wdata(p_wdata), .p_ready(p_ready),
    .m_valid(m_valid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_ready(m_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .grant_src(grant_src), .m_starved(m_starved)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        src;
  } exp_t;

  exp_t        q[$];
  int          tests;
  int          fails;
  logic [31:0] rf[32];
  logic [4:0]  last_a;
  logic [31:0] last_d;
  logic        last_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs forever inside the main initial block; checks the registered outputs after every edge.
  task automatic monitor();
    logic hs;
    exp_t e;
    forever begin
      @(negedge clk);
      hs = (p_valid && p_ready) || (m_valid && m_ready);
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {27'd0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_grant_src", {31'd0, grant_src}, 32'd0);
        last_a = '0; last_d = '0; last_s = 1'b0;
      end else if (hs) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_handshake: got handshake expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("wr_we", {31'd0, we}, {31'd0, e.we});
          chk("wr_waddr", {27'd0, waddr}, {27'd0, e.a});
          chk("wr_wdata", wdata, e.d);
          chk("wr_grant_src", {31'd0, grant_src}, {31'd0, e.src});
          last_a = e.a; last_d = e.d; last_s = e.src;
        end
        if (we) rf[waddr] = wdata;
      end else begin
        chk("idle_we", {31'd0, we}, 32'd0);
        chk("idle_waddr", {27'd0, waddr}, {27'd0, last_a});
        chk("idle_wdata", wdata, last_d);
        chk("idle_grant_src", {31'd0, grant_src}, {31'd0, last_s});
      end
    end
  endtask

  // One clock of stimulus: drive, check the combinational handshake, queue the expected write.
  task automatic cyc(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic epr, input logic emr, input logic est);
    exp_t e;
    p_valid = pv; p_waddr = pa; p_wdata = pd;
    m_valid = mv; m_waddr = ma; m_wdata = md;
    @(negedge clk);
    #1;
    chk("p_ready", {31'd0, p_ready}, {31'd0, epr});
    chk("m_ready", {31'd0, m_ready}, {31'd0, emr});
    chk("m_starved", {31'd0, m_starved}, {31'd0, est});
    if (epr) begin
      e.we = (pa != 5'd0); e.a = pa; e.d = pd; e.src = 1'b0;
      q.push_back(e);
    end
    if (emr) begin
      e.we = (ma != 5'd0); e.a = ma; e.d = md; e.src = 1'b1;
      q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    last_a = '0; last_d = '0; last_s = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    clk = 1'b0;
    rst = 1'b1;
    p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h11;
    m_valid = 1'b1; m_waddr = 5'd2; m_wdata = 32'h22;
    fork
      monitor();
    join_none

    // Power-on reset with both sources requesting.
    #2;
    chk("por_p_ready", {31'd0, p_ready}, 32'd0);
    chk("por_m_ready", {31'd0, m_ready}, 32'd0);
    chk("por_we", {31'd0, we}, 32'd0);
    @(posedge clk); @(posedge clk);
    #3;
    p_valid = 1'b0; m_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Single pipeline write, then one idle cycle showing we drop.
    cyc(1, 5'd3, 32'h1234_5678, 0, 5'd0, 32'd0, 1, 0, 0);
    idle(1);

    // Pipeline hogs the port; M is forced through on the fifth cycle.
    for (int i = 1; i <= 4; i++)
      cyc(1, 5'(i), 32'h100 + 32'(i), 1, 5'd9, 32'hDEAD_BEEF, 1, 0, 0);
    cyc(1, 5'd5, 32'h105, 1, 5'd9, 32'hDEAD_BEEF, 0, 1, 1);
    cyc(1, 5'd5, 32'h105, 0, 5'd0, 32'd0, 1, 0, 0);
    idle(1);

    // Register 0 write: accepted but no enable.
    cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_AAAA, 0, 1, 0);
    idle(1);

    // Idle hold after a write to register 7.
    cyc(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 1, 0, 0);
    idle(3);

    // Same-address collision: P first, M next.
    cyc(1, 5'd5, 32'h1, 1, 5'd5, 32'h2, 1, 0, 0);
    cyc(0, 5'd0, 32'd0, 1, 5'd5, 32'h2, 0, 1, 0);
    idle(2);

    // Reset asserted between edges while a write is showing on the port.
    cyc(1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 1, 0, 0);
    p_valid = 1'b1; m_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_waddr", {27'd0, waddr}, 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    chk("mid_rst_grant_src", {31'd0, grant_src}, 32'd0);
    chk("mid_rst_p_ready", {31'd0, p_ready}, 32'd0);
    chk("mid_rst_m_ready", {31'd0, m_ready}, 32'd0);
    @(posedge clk); @(posedge clk);
    #3;
    p_valid = 1'b0; m_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #2;
    cyc(1, 5'd6, 32'h66, 0, 5'd0, 32'd0, 1, 0, 0);
    idle(2);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("rf5_final", rf[5], 32'h2);
    chk("rf7_final", rf[7], 32'h77);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port between two writeback sources: the main pipeline (P) and a multi-cycle unit such as the divider or a late load (M). It grants at most one source per cycle. It registers the winning write onto the register file's we/waddr/wdata inputs. It also guarantees that M cannot be starved by back-to-back pipeline writes.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register address
STARVE_LIMIT, 4, consecutive denied cycles after which M is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
p_valid  in  1  pipeline source has a write pending
p_waddr  in  ADDR_W  pipeline destination register
p_wdata  in  DATA_W  pipeline write data
p_ready  out  1  pipeline write accepted this cycle (combinational)
m_valid  in  1  multi-cycle source has a write pending
m_waddr  in  ADDR_W  multi-cycle destination register
m_wdata  in  DATA_W  multi-cycle write data
m_ready  out  1  multi-cycle write accepted this cycle (combinational)
we  out  1  register file write enable (registered)
waddr  out  ADDR_W  register file write address (registered)
wdata  out  DATA_W  register file write data (registered)
grant_src  out  1  source of the current registered write, 0 = P, 1 = M (registered)
m_starved  out  1  starvation counter at limit; M has forced priority (combinational from state)

Behaviour:
- Reset (asynchronous, rst=1): we=0, waddr=0, wdata=0, grant_src=0, starvation counter=0. While rst is high, p_ready=0 and m_ready=0.
- Handshake: a transfer occurs when valid && ready in the same cycle. Ready never depends on the other source's data. A source holds valid and its addr/data stable until it sees ready.
- Grant decision, combinational, each cycle:
  - force_m = m_valid && (cnt == STARVE_LIMIT).
  - If force_m, grant M.
  - Else if p_valid, grant P.
  - Else if m_valid, grant M.
  - Else no grant.
  - Exactly one of p_ready/m_ready is 1 when a grant occurs. Both are 0 otherwise.
- Starvation counter cnt, width 4:
  - If m_valid and M is not granted, cnt increments, saturating at STARVE_LIMIT.
  - If M is granted or m_valid=0, cnt is cleared to 0.
  - m_starved = (cnt == STARVE_LIMIT).
- Output register, 1-cycle latency from handshake to we:
  - On a grant: waddr and wdata are loaded from the winner and grant_src is set.
  - we is loaded as 1 if the winner's addr != 0. If addr == 0 the write is accepted (ready=1) but we is loaded as 0, because register $0 is never written.
  - With no grant: we is loaded as 0, and waddr/wdata/grant_src hold their previous values.
  - we is high for exactly one cycle per accepted non-zero write. Back-to-back grants produce continuous we.
- Simultaneous P and M writes to the same address: they are serialized by grant order. The later grant's write is the last one applied. There is no merging.
- Throughput: one write per cycle total. With P continuously valid, M is serviced at least once every STARVE_LIMIT+1 cycles.
- Reset asserted mid-operation: outputs clear immediately and any in-flight registered write is lost. Sources must re-present their requests after reset.

Test Plan:
- Reset: assert rst asynchronously between edges with we=1 pending -> we, waddr, wdata, grant_src go to 0 before the next edge. Both ready signals stay 0 while rst=1.
- Single P write: p_valid=1, p_waddr=3, p_wdata=0x1234_5678 for one cycle -> p_ready=1 that cycle. Next cycle we=1, waddr=3, wdata=0x12345678, grant_src=0. The cycle after, we=0.
- Priority and starvation (STARVE_LIMIT=4): p_valid held 1 with addrs 1,2,3,...; m_valid=1, m_waddr=9, m_wdata=0xDEAD_BEEF -> P is granted 4 consecutive cycles. m_starved=1 on the 5th cycle, where m_ready=1 and p_ready=0. The following cycle shows waddr=9, grant_src=1. cnt returns to 0 and P resumes.
- $0 write: m_valid=1, m_waddr=0, p_valid=0 -> m_ready=1. Next cycle we=0, while waddr=0 and grant_src=1 are still latched.
- Idle hold: after a write to addr 7, drop all valids for 3 cycles -> we=0 and waddr=7 held throughout. Both ready signals stay 0.
- Same-address serialization: P and M both target addr 5 with P data 0x1 and M data 0x2, cnt=0 -> P is written first (wdata=0x1), then M on the next cycle (wdata=0x2). The register file ends holding 0x2.
